// File: rtl/router_port_tx.sv
// Serializes byte packets onto one router input port: address, pad, payload.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   s_valid/s_ready        byte-stream handshake from the packet source
//   s_data, s_last, s_da   payload byte, end-of-packet flag, destination
//   busy_n                 router busy (low = busy), honoured only in IDLE
//   din, frame_n, valid_n  registered serial lines to the router
//   pkt_done               one-cycle pulse after the last payload bit
module router_port_tx #(
  parameter int PAD_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic [3:0] s_da,
  input  logic       busy_n,
  output logic       din,
  output logic       frame_n,
  output logic       valid_n,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PAD,
    DATA,
    WAIT,
    GAP
  } state_e;

  localparam logic [3:0] PAD_LAST = 4'(PAD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] da_q, da_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;

  logic       din_q, din_d;
  logic       frame_n_q, frame_n_d;
  logic       valid_n_q, valid_n_d;
  logic       pkt_done_q, pkt_done_d;

  logic       xfer;

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      IDLE:    s_ready = busy_n;
      DATA:    s_ready = (cnt_q == 4'd7) && !last_q;
      WAIT:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign xfer = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    da_d    = da_q;
    byte_d  = byte_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          da_d    = s_da;
          byte_d  = s_data;
          last_d  = s_last;
          cnt_d   = 4'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          state_d = PAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PAD: begin
        if (cnt_q == PAD_LAST) begin
          cnt_d   = 4'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (cnt_q == 4'd7) begin
          cnt_d = 4'd0;
          if (last_q) begin
            state_d = GAP;
          end else if (xfer) begin
            // next byte chains straight on, no bubble
            byte_d = s_data;
            last_d = s_last;
          end else begin
            state_d = WAIT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (xfer) begin
          byte_d  = s_data;
          last_d  = s_last;
          cnt_d   = 4'd0;
          state_d = DATA;
        end
      end
      GAP: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered lines
  // line up with the state the FSM is in during that cycle.
  always_comb begin
    din_d      = 1'b0;
    frame_n_d  = 1'b1;
    valid_n_d  = 1'b1;
    pkt_done_d = 1'b0;
    unique case (state_d)
      ADDR: begin
        din_d     = da_d[cnt_d[1:0]];
        frame_n_d = 1'b0;
      end
      PAD: begin
        din_d     = 1'b1;
        frame_n_d = 1'b0;
      end
      DATA: begin
        din_d     = byte_d[cnt_d[2:0]];
        valid_n_d = 1'b0;
        frame_n_d = (cnt_d == 4'd7) && last_d;
      end
      WAIT: begin
        frame_n_d = 1'b0;
      end
      GAP: begin
        pkt_done_d = 1'b1;
      end
      default: begin
        din_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      da_q       <= 4'd0;
      byte_q     <= 8'd0;
      last_q     <= 1'b0;
      din_q      <= 1'b0;
      frame_n_q  <= 1'b1;
      valid_n_q  <= 1'b1;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      da_q       <= da_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      din_q      <= din_d;
      frame_n_q  <= frame_n_d;
      valid_n_q  <= valid_n_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign din      = din_q;
  assign frame_n  = frame_n_q;
  assign valid_n  = valid_n_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_router_port_tx.sv
// Testbench for router_port_tx: cycle table, directed corners,
// and randomized packets checked by a deframing receiver model.
module tb_router_port_tx;

  localparam int PAD = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [3:0] s_da;
  logic       busy_n;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       pkt_done;

  router_port_tx #(.PAD_CYCLES(PAD)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_da     (s_da),
    .busy_n   (busy_n),
    .din      (din),
    .frame_n  (frame_n),
    .valid_n  (valid_n),
    .pkt_done (pkt_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // expected packets, in send order
  logic [3:0] exp_da[$];
  int         exp_len[$];
  logic [7:0] exp_bytes[$];
  int         n_sent = 0;

  task automatic push_exp(input logic [3:0] da, input logic [7:0] b[$]);
    exp_da.push_back(da);
    exp_len.push_back(b.size());
    foreach (b[i]) exp_bytes.push_back(b[i]);
    n_sent++;
  endtask

  // receiver model: deframes the serial lines
  logic       mon_en = 1'b0;
  logic       in_frm = 1'b0;
  logic       done_exp = 1'b0;
  logic       expect_abort = 1'b0;
  int         fpos, nbits, pad_n, wait_n, wait_ok, hdr_bad;
  int         gap_cnt = 0;
  int         last_gap = -1;
  int         frames = 0;
  int         last_flen, last_wait, last_wait_ok, last_nbits;
  logic [3:0] addr;
  logic [7:0] cur;
  logic [7:0] got[$];
  int         rdy_bits[$];
  int         last_rdy[$];

  task automatic end_frame();
    logic [3:0] eda;
    int         elen;
    logic [7:0] eb;
    in_frm       = 1'b0;
    gap_cnt      = 0;
    done_exp     = 1'b1;
    frames++;
    last_flen    = 4 + pad_n + wait_n + nbits - 1;
    last_wait    = wait_n;
    last_wait_ok = wait_ok;
    last_nbits   = nbits;
    last_rdy     = rdy_bits;
    if (exp_da.size() == 0) begin
      check("frame_unexpected", 1, 0);
    end else begin
      eda  = exp_da.pop_front();
      elen = exp_len.pop_front();
      check("addr", 32'(addr), 32'(eda));
      check("pad_cycles", pad_n, PAD);
      check("hdr_bad", hdr_bad, 0);
      check("payload_bits", nbits, 8 * elen);
      for (int j = 0; j < elen; j++) begin
        eb = exp_bytes.pop_front();
        if (j < got.size())
          check($sformatf("byte%0d", j), 32'(got[j]), 32'(eb));
        else
          check($sformatf("byte%0d_missing", j), 0, 1);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("pkt_done", 32'(pkt_done), 32'(done_exp));
      done_exp = 1'b0;
      if (!in_frm && frame_n == 1'b0) begin
        in_frm   = 1'b1;
        fpos     = 0;
        nbits    = 0;
        pad_n    = 0;
        wait_n   = 0;
        wait_ok  = 0;
        hdr_bad  = 0;
        addr     = 4'd0;
        got.delete();
        rdy_bits.delete();
        last_gap = gap_cnt;
      end
      if (in_frm) begin
        if (frame_n == 1'b1 && valid_n == 1'b1) begin
          check("abort_expected", 32'(expect_abort), 1);
          expect_abort = 1'b0;
          in_frm       = 1'b0;
          gap_cnt      = 0;
        end else if (fpos < 4) begin
          addr[fpos] = din;
          if (valid_n != 1'b1) hdr_bad++;
          fpos++;
        end else if (valid_n == 1'b0) begin
          cur[nbits % 8] = din;
          if (s_ready) rdy_bits.push_back(nbits);
          nbits++;
          if (nbits % 8 == 0) got.push_back(cur);
          if (frame_n == 1'b1) end_frame();
        end else if (nbits == 0) begin
          pad_n++;
          if (din != 1'b1) hdr_bad++;
        end else begin
          wait_n++;
          if (din == 1'b0 && s_ready) wait_ok++;
        end
      end else begin
        gap_cnt++;
      end
    end
  end

  // cycle table
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [3:0] da;
    logic       bn;
    logic       rdy;
    logic       di;
    logic       fn;
    logic       vn;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic v, input logic [7:0] d,
                         input logic l, input logic [3:0] da,
                         input logic bn, input logic rdy,
                         input logic di, input logic fn,
                         input logic vn, input logic dn);
    vec_t r;
    r.v  = v;
    r.d  = d;
    r.l  = l;
    r.da = da;
    r.bn = bn;
    r.rdy = rdy;
    r.di = di;
    r.fn = fn;
    r.vn = vn;
    r.dn = dn;
    tbl.push_back(r);
  endtask

  // one-byte packet offered in IDLE; busy_n held low inside the frame
  task automatic add_pkt(input logic [3:0] da, input logic [7:0] b);
    logic [7:0] q[$];
    q.push_back(b);
    push_exp(da, q);
    add_row(1'b1, b, 1'b1, da, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      add_row(1'b1, ~b, 1'b0, ~da, 1'b0, 1'b0, da[i], 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < PAD; i++)
      add_row(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add_row(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, b[i], (i == 7), 1'b0, 1'b0);
    add_row(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // source driver
  logic rand_busy = 1'b0;
  logic smp_rdy;

  task automatic cyc();
    if (rand_busy) busy_n = ($urandom_range(0, 3) != 0);
    @(negedge clock);
    smp_rdy = s_ready;
    @(posedge clock);
    #1;
  endtask

  // d[i]: cycles the source withholds byte i while s_ready is high
  task automatic src_send(input logic [3:0] da, input logic [7:0] b[$],
                          input int d[$]);
    int   n;
    int   t;
    logic hs;
    foreach (b[i]) begin
      s_valid = 1'b0;
      s_data  = b[i];
      s_last  = (i == b.size() - 1);
      s_da    = (i == 0) ? da : 4'($urandom);
      n = 0;
      t = 0;
      while (n < d[i] && t < 400) begin
        cyc();
        if (smp_rdy) n++;
        t++;
      end
      s_valid = 1'b1;
      hs = 1'b0;
      while (!hs && t < 400) begin
        cyc();
        hs = smp_rdy;
        t++;
      end
      if (!hs) begin
        check("src_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int tgt);
    int t = 0;
    while (frames < tgt && t < 600) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("frames_done", frames, tgt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pb[$];
    int         pd[$];
    int         len;
    logic [3:0] rda;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    s_da    = 4'h0;
    busy_n  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_din", 32'(din), 0);
    check("rst_frame_n", 32'(frame_n), 1);
    check("rst_valid_n", 32'(valid_n), 1);
    check("rst_pkt_done", 32'(pkt_done), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready_busy_hi", 32'(s_ready), 1);
    busy_n = 1'b0;
    #1;
    check("idle_ready_busy_lo", 32'(s_ready), 0);
    busy_n = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // single-byte and back-to-back packets, cycle by cycle
    add_pkt(4'h5, 8'hA5);
    add_pkt(4'h0, 8'h3B);
    add_pkt(4'h9, 8'hC6);
    add_row(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    foreach (tbl[i]) begin
      s_valid = tbl[i].v;
      s_data  = tbl[i].d;
      s_last  = tbl[i].l;
      s_da    = tbl[i].da;
      busy_n  = tbl[i].bn;
      @(negedge clock);
      check($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_din", i), 32'(din), 32'(tbl[i].di));
      check($sformatf("tbl%0d_frame_n", i), 32'(frame_n), 32'(tbl[i].fn));
      check($sformatf("tbl%0d_valid_n", i), 32'(valid_n), 32'(tbl[i].vn));
      check($sformatf("tbl%0d_pkt_done", i), 32'(pkt_done), 32'(tbl[i].dn));
      @(posedge clock);
      #1;
    end
    s_valid = 1'b0;
    busy_n  = 1'b1;
    wait_frames(n_sent);
    check("b2b_gap", last_gap, 2);

    // three-byte streaming packet
    pb = '{8'h01, 8'h80, 8'hFF};
    pd = '{0, 0, 0};
    push_exp(4'hF, pb);
    src_send(4'hF, pb, pd);
    wait_frames(n_sent);
    check("stream_flen", last_flen, 4 + PAD + 24 - 1);
    check("stream_bits", last_nbits, 24);
    check("stream_wait", last_wait, 0);
    check("stream_rdy_n", last_rdy.size(), 2);
    check("stream_rdy0", (last_rdy.size() > 0) ? last_rdy[0] : -1, 7);
    check("stream_rdy1", (last_rdy.size() > 1) ? last_rdy[1] : -1, 15);

    // underrun: second byte withheld for 3 cycles
    pb = '{8'h3C, 8'h96};
    pd = '{0, 3};
    push_exp(4'h3, pb);
    src_send(4'h3, pb, pd);
    wait_frames(n_sent);
    check("underrun_wait", last_wait, 3);
    check("underrun_wait_ok", last_wait_ok, 3);
    check("underrun_flen", last_flen, 4 + PAD + 16 - 1 + 3);

    // busy holds the block in IDLE
    pb = '{8'h81};
    push_exp(4'hD, pb);
    s_valid = 1'b1;
    s_data  = 8'h81;
    s_last  = 1'b1;
    s_da    = 4'hD;
    busy_n  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("busy%0d_ready", i), 32'(s_ready), 0);
      check($sformatf("busy%0d_frame_n", i), 32'(frame_n), 1);
      check($sformatf("busy%0d_valid_n", i), 32'(valid_n), 1);
      @(posedge clock);
      #1;
    end
    busy_n = 1'b1;
    @(negedge clock);
    check("busy_release_ready", 32'(s_ready), 1);
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    @(negedge clock);
    check("busy_start_frame_n", 32'(frame_n), 0);
    check("busy_start_din", 32'(din), 1);
    check("busy_start_valid_n", 32'(valid_n), 1);
    @(posedge clock);
    #1;
    wait_frames(n_sent);

    // reset during payload bit 3
    pb = '{8'h5A};
    pd = '{0};
    src_send(4'h7, pb, pd);
    repeat (12) begin
      @(posedge clock);
      #1;
    end
    expect_abort = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_valid_n", 32'(valid_n), 0);
    check("rst_mid_bit3", 32'(din), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_abort_frame_n", 32'(frame_n), 1);
    check("rst_abort_valid_n", 32'(valid_n), 1);
    check("rst_abort_din", 32'(din), 0);
    check("rst_abort_done", 32'(pkt_done), 0);
    @(posedge clock);
    #1;
    check("rst_abort_seen", 32'(expect_abort), 0);
    pb = '{8'hE7, 8'h18};
    pd = '{0, 0};
    push_exp(4'hA, pb);
    src_send(4'hA, pb, pd);
    wait_frames(n_sent);

    // randomized packets with random busy and source gaps
    rand_busy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      pb.delete();
      pd.delete();
      len = $urandom_range(1, 4);
      rda = 4'($urandom);
      for (int i = 0; i < len; i++) begin
        pb.push_back(8'($urandom));
        pd.push_back($urandom_range(0, 3));
      end
      push_exp(rda, pb);
      src_send(rda, pb, pd);
    end
    rand_busy = 1'b0;
    busy_n = 1'b1;
    wait_frames(n_sent);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("exp_queue_empty", exp_da.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
